// File: rtl/regs_led_hex_pkg.sv
// Shared constants for the LED / seven-segment output peripheral:
// register offsets, active-low segment font and the blank pattern.
package regs_led_hex_pkg;

   localparam logic [11:0] ADDR_LED  = 12'h000;
   localparam logic [11:0] ADDR_HEX  = 12'h004;
   localparam logic [11:0] ADDR_EN   = 12'h008;
   localparam logic [11:0] ADDR_DP   = 12'h00C;
   localparam logic [11:0] ADDR_SRST = 12'h024;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Packed so FONT[n] selects glyph n; listed from F down to 0, bits {g,f,e,d,c,b,a}.
   localparam logic [15:0][6:0] FONT = {
      7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
      7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
      7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
      7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational nibble to active-low seven-segment pattern.
module hex7seg_decoder
   import regs_led_hex_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = FONT[i_nibble];

endmodule

// File: rtl/regs_led_hex.sv
// Memory-mapped LED / 8-digit seven-segment peripheral with registered
// read-back and a free-running digit scanner.
module regs_led_hex
   import regs_led_hex_pkg::*;
#(
   parameter int SCAN_DIV = 100000
) (
   input  logic        CLK100,
   input  logic        resetn,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic [15:0] LED,
   output logic [7:0]  AN,
   output logic [6:0]  SEG,
   output logic        DP
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [15:0]      r_led;
   logic [31:0]      r_hex;
   logic [7:0]       r_en;
   logic [7:0]       r_dp;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic [31:0]      r_rdata;
   logic [7:0]       r_an;
   logic [6:0]       r_seg;
   logic             r_dp_n;

   logic [11:0] w_addr;
   logic        w_wr;
   logic        w_rd;
   logic        w_srst;
   logic [3:0]  w_nibble;
   logic [6:0]  w_seg;
   logic [31:0] w_rd_data;
   logic        w_unused;

   assign w_addr   = addr_i[11:0];
   assign w_wr     = req_i && we_i;
   assign w_rd     = req_i && !we_i;
   assign w_srst   = w_wr && (w_addr == ADDR_SRST) && wdata_i[0];
   assign w_nibble = r_hex[4*r_idx +: 4];
   assign w_unused = ^addr_i[31:12];

   hex7seg_decoder u_dec (
      .i_nibble (w_nibble),
      .o_seg    (w_seg)
   );

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_rd_data = '0;
      case (w_addr)
         ADDR_LED: w_rd_data = {16'h0000, r_led};
         ADDR_HEX: w_rd_data = r_hex;
         ADDR_EN:  w_rd_data = {24'h000000, r_en};
         ADDR_DP:  w_rd_data = {24'h000000, r_dp};
         default:  w_rd_data = '0;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK100) begin
      if (!resetn) begin
         r_led   <= '0;
         r_hex   <= '0;
         r_en    <= '0;
         r_dp    <= '0;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_rdata <= '0;
         r_an    <= 8'hFF;
         r_seg   <= SEG_BLANK;
         r_dp_n  <= 1'b1;
      end else begin
         if (w_rd)
            r_rdata <= w_rd_data;

         // Soft reset mirrors resetn except that read data is preserved.
         if (w_srst) begin
            r_led  <= '0;
            r_hex  <= '0;
            r_en   <= '0;
            r_dp   <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_an   <= 8'hFF;
            r_seg  <= SEG_BLANK;
            r_dp_n <= 1'b1;
         end else begin
            if (w_wr) begin
               case (w_addr)
                  ADDR_LED: r_led <= wdata_i[15:0];
                  ADDR_HEX: r_hex <= wdata_i;
                  ADDR_EN:  r_en  <= wdata_i[7:0];
                  ADDR_DP:  r_dp  <= wdata_i[7:0];
                  default:  ;
               endcase
            end

            if (r_cnt == CNT_MAX) begin
               r_cnt <= '0;
               r_idx <= r_idx + 3'd1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end

            // Display is built from pre-edge idx/registers, so a slot never mixes old and new data.
            if (r_en[r_idx]) begin
               r_an   <= ~(8'd1 << r_idx);
               r_seg  <= w_seg;
               r_dp_n <= ~r_dp[r_idx];
            end else begin
               r_an   <= 8'hFF;
               r_seg  <= SEG_BLANK;
               r_dp_n <= 1'b1;
            end
         end
      end
   end

   assign rdata_o = r_rdata;
   assign LED     = r_led;
   assign AN      = r_an;
   assign SEG     = r_seg;
   assign DP      = r_dp_n;

endmodule

// File: tb/tb_regs_led_hex.sv
// Bench for regs_led_hex: behavioural model checked every cycle, directed
// scenarios with literal expectations, then randomized bus traffic.
module tb_regs_led_hex;

   localparam int SCAN_DIV = 4;

   logic        CLK100 = 1'b0;
   logic        resetn = 1'b0;
   logic        req_i  = 1'b0;
   logic        we_i   = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [31:0] rdata_o;
   logic [15:0] LED;
   logic [7:0]  AN;
   logic [6:0]  SEG;
   logic        DP;

   int n_checks = 0;
   int n_errors = 0;

   regs_led_hex #(.SCAN_DIV(SCAN_DIV)) dut (
      .CLK100  (CLK100),
      .resetn  (resetn),
      .req_i   (req_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o),
      .LED     (LED),
      .AN      (AN),
      .SEG     (SEG),
      .DP      (DP)
   );

   always #5 CLK100 = ~CLK100;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Glyphs indexed by digit value, active-low {g,f,e,d,c,b,a}.
   logic [6:0] font_tb [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic [15:0] m_led;
   logic [31:0] m_hex;
   logic [7:0]  m_en, m_dp;
   int          m_cnt, m_idx;
   logic [31:0] m_rdata;
   logic [7:0]  m_an;
   logic [6:0]  m_seg;
   logic        m_dpo;
   bit          m_valid = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [11:0] a);
      case (a)
         12'h000: return 32'(m_led);
         12'h004: return m_hex;
         12'h008: return 32'(m_en);
         12'h00C: return 32'(m_dp);
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_blank();
      m_an  = 8'hFF;
      m_seg = 7'h7F;
      m_dpo = 1'b1;
   endtask

   task automatic model_clear();
      m_led = 0; m_hex = 0; m_en = 0; m_dp = 0; m_cnt = 0; m_idx = 0;
   endtask

   always @(posedge CLK100) begin
      logic [11:0] a;
      bit srst;
      if (!resetn) begin
         model_clear();
         model_blank();
         m_rdata = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         a = addr_i[11:0];
         srst = req_i && we_i && (a == 12'h024) && wdata_i[0];
         if (req_i && !we_i) m_rdata = model_read(a);
         if (srst) begin
            model_clear();
            model_blank();
         end else begin
            if (m_en[m_idx]) begin
               m_an  = 8'(255 - (1 << m_idx));
               m_seg = font_tb[(m_hex >> (4 * m_idx)) % 16];
               m_dpo = !m_dp[m_idx];
            end else begin
               model_blank();
            end
            if (req_i && we_i) begin
               case (a)
                  12'h000: m_led = wdata_i[15:0];
                  12'h004: m_hex = wdata_i;
                  12'h008: m_en  = wdata_i[7:0];
                  12'h00C: m_dp  = wdata_i[7:0];
                  default: ;
               endcase
            end
            m_cnt++;
            if (m_cnt == SCAN_DIV) begin
               m_cnt = 0;
               m_idx = (m_idx + 1) % 8;
            end
         end
      end
   end

   always @(negedge CLK100) begin
      if (m_valid) begin
         check("model_rdata", rdata_o, m_rdata);
         check("model_led", 32'(LED), 32'(m_led));
         check("model_an", 32'(AN), 32'(m_an));
         check("model_seg", 32'(SEG), 32'(m_seg));
         check("model_dp", 32'(DP), 32'(m_dpo));
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK100);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
      idle(1);
      req_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a);
      req_i = 1'b1; we_i = 1'b0; addr_i = a;
      idle(1);
      req_i = 1'b0;
   endtask

   task automatic wait_an(input logic [7:0] v, input string nm);
      for (int k = 0; k < 64; k++) begin
         if (AN == v) break;
         idle(1);
      end
      check(nm, 32'(AN), 32'(v));
   endtask

   task automatic check_blank(input string nm);
      check({nm, "_an"}, 32'(AN), 32'h0000_00FF);
      check({nm, "_seg"}, 32'(SEG), 32'h0000_007F);
      check({nm, "_dp"}, 32'(DP), 32'h1);
      check({nm, "_led"}, 32'(LED), 32'h0);
   endtask

   task automatic check_restart(input string nm);
      wr(32'h008, 32'hFF);
      idle(1);
      check({nm, "_restart_an"}, 32'(AN), 32'h0000_00FE);
      rd(32'h000); check({nm, "_rd_led"}, rdata_o, 32'h0);
      rd(32'h004); check({nm, "_rd_hex"}, rdata_o, 32'h0);
      rd(32'h00C); check({nm, "_rd_dp"}, rdata_o, 32'h0);
      rd(32'h024); check({nm, "_rd_srst"}, rdata_o, 32'h0);
   endtask

   initial begin
      logic [7:0] prev;
      int n;
      logic [3:0] seen;

      idle(2);
      resetn = 1'b1;
      check_blank("reset");
      rd(32'h000); check("reset_rd_led", rdata_o, 32'h0);
      rd(32'h004); check("reset_rd_hex", rdata_o, 32'h0);
      rd(32'h008); check("reset_rd_en", rdata_o, 32'h0);
      rd(32'h00C); check("reset_rd_dp", rdata_o, 32'h0);

      wr(32'h000, 32'hFFFF_A5C3);
      check("led_write", 32'(LED), 32'h0000_A5C3);
      rd(32'h000);
      check("led_read", rdata_o, 32'h0000_A5C3);

      wr(32'h004, 32'h89AB_CDEF);
      wr(32'h00C, 32'h01);
      wr(32'h008, 32'hFF);
      wait_an(8'hFE, "digit0_an");
      check("digit0_seg", 32'(SEG), 32'(7'b0001110));
      check("digit0_dp", 32'(DP), 32'h0);
      wait_an(8'h7F, "digit7_an");
      check("digit7_seg", 32'(SEG), 32'(7'b0000000));
      check("digit7_dp", 32'(DP), 32'h1);
      idle(SCAN_DIV);
      check("wrap_7_to_0", 32'(AN), 32'h0000_00FE);

      prev = AN;
      for (int k = 0; k < 20 && AN == prev; k++) idle(1);
      prev = AN;
      n = 0;
      while (AN == prev && n < 20) begin
         idle(1);
         n++;
      end
      check("slot_len", 32'(n), 32'(SCAN_DIV));

      wr(32'h008, 32'h05);
      idle(2);
      seen = '0;
      for (int k = 0; k < 8 * SCAN_DIV + 4; k++) begin
         case (AN)
            8'hFE:   seen[3] = 1'b1;
            8'hFB:   seen[2] = 1'b1;
            8'hFF:   seen[1] = 1'b1;
            default: seen[0] = 1'b1;
         endcase
         idle(1);
      end
      check("en05_patterns", 32'(seen), 32'(4'b1110));

      rd(32'h010); check("unmapped_rd", rdata_o, 32'h0);
      wr(32'h010, 32'hDEAD_BEEF);
      rd(32'h000); check("after_unmapped_led", rdata_o, 32'h0000_A5C3);
      rd(32'h004); check("after_unmapped_hex", rdata_o, 32'h89AB_CDEF);
      rd(32'h008); check("after_unmapped_en", rdata_o, 32'h0000_0005);
      rd(32'h00C); check("after_unmapped_dp", rdata_o, 32'h0000_0001);

      wr(32'h024, 32'h0);
      rd(32'h000); check("srst0_noop", rdata_o, 32'h0000_A5C3);

      wr(32'h008, 32'hFF);
      rd(32'h004);
      wait_an(8'hDF, "srst_idx5");
      wr(32'h024, 32'h1);
      check_blank("srst");
      check("srst_rdata_hold", rdata_o, 32'h89AB_CDEF);
      check_restart("srst");

      wr(32'h004, 32'h1234_5678);
      wr(32'h000, 32'h0000_00FF);
      rd(32'h004);
      wait_an(8'hDF, "rst_idx5");
      resetn = 1'b0;
      idle(1);
      resetn = 1'b1;
      check_blank("rstn");
      check("rstn_rdata", rdata_o, 32'h0);
      check_restart("rstn");

      for (int k = 0; k < 3000; k++) begin
         int r;
         r = $urandom_range(0, 19);
         resetn  = ($urandom_range(0, 499) != 0);
         req_i   = $urandom_range(0, 1);
         we_i    = $urandom_range(0, 1);
         wdata_i = $urandom;
         addr_i  = $urandom;
         if (r == 4)      addr_i[11:0] = 12'h024;
         else if (r == 5) addr_i[11:0] = 12'h010;
         else if (r != 6) addr_i[11:0] = 12'(4 * (r % 4));
         idle(1);
      end
      resetn = 1'b1;
      req_i  = 1'b0;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
